// File: rtl/risc_pkg.sv
// Shared definitions for the RISC sequencer: opcode values, ALU-op membership,
// the phase/state encoding and the bundle of control strobes.
package risc_pkg;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  // Phases 0-7 keep their numeric value so the low bits double as the phase
  // output; HALTED sits outside that range.
  typedef enum logic [3:0] {
    INST_ADDR  = 4'd0,
    INST_FETCH = 4'd1,
    INST_LOAD  = 4'd2,
    IDLE       = 4'd3,
    OP_ADDR    = 4'd4,
    OP_FETCH   = 4'd5,
    ALU_OP     = 4'd6,
    STORE      = 4'd7,
    HALTED     = 4'd8
  } state_t;

  typedef struct packed {
    logic sel;
    logic rd;
    logic wr;
    logic ld_ir;
    logic ld_ac;
    logic pc_inc;
    logic pc_load;
    logic data_e;
    logic halt;
  } ctrl_t;

  // Instructions that read an operand from memory and write the accumulator.
  function automatic logic is_aluop(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/risc_controller.sv
// Eight-phase instruction sequencer: one state register plus a Moore decode of
// state and opcode driving the datapath strobes.
module risc_controller
  import risc_pkg::*;
(
  input  logic       clk,
  input  logic       clear,
  input  logic [2:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  input  logic       start,
  output logic       sel,
  output logic       rd,
  output logic       wr,
  output logic       ld_ir,
  output logic       ld_ac,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       data_e,
  output logic       halt,
  output logic [2:0] phase
);

  state_t state;
  ctrl_t  ctrl;
  logic   alu;

  assign alu = is_aluop(opcode);

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state <= INST_ADDR;
    end else begin
      case (state)
        INST_ADDR:  state <= INST_FETCH;
        INST_FETCH: if (mem_ready) state <= INST_LOAD;
        INST_LOAD:  state <= IDLE;
        IDLE:       state <= OP_ADDR;
        OP_ADDR:    state <= (opcode == OP_HLT) ? HALTED : OP_FETCH;
        // Only instructions that consume an operand wait for read data.
        OP_FETCH:   if (!alu || mem_ready) state <= ALU_OP;
        ALU_OP:     state <= STORE;
        STORE:      state <= INST_ADDR;
        HALTED:     if (start) state <= INST_ADDR;
        default:    state <= INST_ADDR;
      endcase
    end
  end

  always_comb begin
    ctrl = '0;
    case (state)
      INST_ADDR: begin
        ctrl.sel = 1'b1;
      end
      INST_FETCH: begin
        ctrl.sel = 1'b1;
        ctrl.rd  = 1'b1;
      end
      INST_LOAD, IDLE: begin
        ctrl.sel   = 1'b1;
        ctrl.rd    = 1'b1;
        ctrl.ld_ir = 1'b1;
      end
      OP_ADDR: begin
        ctrl.pc_inc = 1'b1;
      end
      OP_FETCH: begin
        ctrl.rd = alu;
      end
      ALU_OP: begin
        ctrl.rd      = alu;
        ctrl.pc_inc  = (opcode == OP_SKZ) && zero;
        ctrl.pc_load = (opcode == OP_JMP);
        ctrl.data_e  = (opcode == OP_STO);
      end
      STORE: begin
        ctrl.rd      = alu;
        ctrl.ld_ac   = alu;
        ctrl.pc_load = (opcode == OP_JMP);
        ctrl.wr      = (opcode == OP_STO);
        ctrl.data_e  = (opcode == OP_STO);
      end
      HALTED: begin
        ctrl.halt = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  always_comb begin
    sel     = ctrl.sel;
    rd      = ctrl.rd;
    wr      = ctrl.wr;
    ld_ir   = ctrl.ld_ir;
    ld_ac   = ctrl.ld_ac;
    pc_inc  = ctrl.pc_inc;
    pc_load = ctrl.pc_load;
    data_e  = ctrl.data_e;
    halt    = ctrl.halt;
    phase   = (state == HALTED) ? 3'd0 : state[2:0];
  end

endmodule
